// File: rtl/ring_decoder_monitor.sv
// Monitors a one-hot ring counter: decodes the set bit, flags one-hot and rotation
// errors, acquires lock after LOCK_N in-sequence steps and counts revolutions.
module ring_decoder_monitor #(
    parameter  int WIDTH  = 4,
    parameter  int LOCK_N = 4,
    parameter  int REV_W  = 8,
    parameter  int ERR_W  = 8,
    localparam int IW     = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Ring_in,
    input  logic             Ring_valid,
    output logic [IW-1:0]    Index,
    output logic             Index_valid,
    output logic             Onehot_err,
    output logic             Seq_err,
    output logic             Locked,
    output logic [REV_W-1:0] Rev_count,
    output logic [ERR_W-1:0] Err_count
);

    localparam int GW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return seen && !multi;
    endfunction

    function automatic logic [IW-1:0] encode(input logic [WIDTH-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    state_t           state_p1, state_p0;
    logic [GW-1:0]    good_p1, good_p0, good_inc;
    logic [WIDTH-1:0] prev_p1, prev_p0, expected;
    logic [IW-1:0]    index_p1, index_p0;
    logic             vld_p1, vld_p0;
    logic             oh_err_p1, oh_err_p0;
    logic             seq_err_p1, seq_err_p0;
    logic [REV_W-1:0] rev_p1, rev_p0;
    logic [ERR_W-1:0] err_p1, err_p0;
    logic             onehot, inseq;

    // Stage 0: classify the incoming sample against the last accepted one
    assign expected = {prev_p1[WIDTH-2:0], prev_p1[WIDTH-1]};
    assign onehot   = is_onehot(Ring_in);
    assign inseq    = onehot && (Ring_in == expected);
    assign good_inc = good_p1 + GW'(1);

    always_comb begin
        state_p0   = state_p1;
        good_p0    = good_p1;
        prev_p0    = prev_p1;
        index_p0   = index_p1;
        vld_p0     = 1'b0;
        oh_err_p0  = 1'b0;
        seq_err_p0 = 1'b0;
        rev_p0     = rev_p1;
        err_p0     = err_p1;
        if (Ring_valid) begin
            if (!onehot) begin
                oh_err_p0 = 1'b1;
                state_p0  = IDLE;
                good_p0   = '0;
            end else begin
                index_p0 = encode(Ring_in);
                vld_p0   = 1'b1;
                prev_p0  = Ring_in;
                case (state_p1)
                    IDLE: begin
                        state_p0 = ACQUIRE;
                        good_p0  = '0;
                    end
                    ACQUIRE: begin
                        if (inseq) begin
                            good_p0 = good_inc;
                            if (good_inc == GW'(LOCK_N)) state_p0 = LOCKED;
                        end else begin
                            seq_err_p0 = 1'b1;
                            good_p0    = '0;
                        end
                    end
                    LOCKED: begin
                        if (inseq) begin
                            // Landing on bit 0 closes one full revolution
                            if (Ring_in[0]) rev_p0 = rev_p1 + REV_W'(1);
                        end else begin
                            seq_err_p0 = 1'b1;
                            state_p0   = ACQUIRE;
                            good_p0    = '0;
                        end
                    end
                    default: begin
                        state_p0 = IDLE;
                        good_p0  = '0;
                    end
                endcase
            end
            if (oh_err_p0 || seq_err_p0) err_p0 = sat_inc(err_p1);
        end
    end

    // Stage 1: registered state and outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_p1   <= IDLE;
            good_p1    <= '0;
            prev_p1    <= '0;
            index_p1   <= '0;
            vld_p1     <= 1'b0;
            oh_err_p1  <= 1'b0;
            seq_err_p1 <= 1'b0;
            rev_p1     <= '0;
            err_p1     <= '0;
        end else begin
            state_p1   <= state_p0;
            good_p1    <= good_p0;
            prev_p1    <= prev_p0;
            index_p1   <= index_p0;
            vld_p1     <= vld_p0;
            oh_err_p1  <= oh_err_p0;
            seq_err_p1 <= seq_err_p0;
            rev_p1     <= rev_p0;
            err_p1     <= err_p0;
        end
    end

    assign Index       = index_p1;
    assign Index_valid = vld_p1;
    assign Onehot_err  = oh_err_p1;
    assign Seq_err     = seq_err_p1;
    assign Locked      = (state_p1 == LOCKED);
    assign Rev_count   = rev_p1;
    assign Err_count   = err_p1;

endmodule

// File: tb/tb_ring_decoder_monitor.sv
// Directed vector bench for ring_decoder_monitor (WIDTH=4, LOCK_N=4) plus an
// ERR_W=2 instance for error-counter saturation.
module tb_ring_decoder_monitor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, vld;
    logic [3:0] ring;
    logic [1:0] idx;
    logic       iv, oh, sq, lk;
    logic [7:0] rev, err;

    logic       rst2, vld2;
    logic [3:0] ring2;
    logic [1:0] idx2;
    logic       iv2, oh2, sq2, lk2;
    logic [7:0] rev2;
    logic [1:0] err2;

    ring_decoder_monitor #(.WIDTH(4), .LOCK_N(4), .REV_W(8), .ERR_W(8)) dut (
        .Clock(clk), .Reset(rst), .Ring_in(ring), .Ring_valid(vld),
        .Index(idx), .Index_valid(iv), .Onehot_err(oh), .Seq_err(sq),
        .Locked(lk), .Rev_count(rev), .Err_count(err)
    );

    ring_decoder_monitor #(.WIDTH(4), .LOCK_N(4), .REV_W(8), .ERR_W(2)) dut_sat (
        .Clock(clk), .Reset(rst2), .Ring_in(ring2), .Ring_valid(vld2),
        .Index(idx2), .Index_valid(iv2), .Onehot_err(oh2), .Seq_err(sq2),
        .Locked(lk2), .Rev_count(rev2), .Err_count(err2)
    );

    typedef struct {
        int rst, vld, ring;
        int idx, iv, oh, sq, lk, rev, err;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input int r, input int v, input int rg, input int ix, input int i_v,
                       input int o, input int s, input int l, input int rv, input int e);
        vec_t x;
        x.rst = r;  x.vld = v; x.ring = rg;
        x.idx = ix; x.iv = i_v; x.oh = o; x.sq = s; x.lk = l; x.rev = rv; x.err = e;
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input int row, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
        end
    endtask

    initial begin
        int sat_exp[5];
        sat_exp = '{1, 2, 3, 3, 3};

        // rst vld ring      idx iv oh sq lk rev err
        add(1, 0, 'b0000,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 'b1111,  0, 0, 0, 0, 0, 0, 0);
        // nominal lock, 12 samples
        add(0, 1, 'b0001,  0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 0, 0, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 0, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 0, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 1, 0, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 1, 0);
        // one-hot violations
        add(0, 1, 'b0110,  3, 0, 1, 0, 0, 1, 1);
        add(0, 1, 'b0000,  3, 0, 1, 0, 0, 1, 2);
        // relock from IDLE, end locked with prev=0010
        add(0, 1, 'b0001,  0, 1, 0, 0, 0, 1, 2);
        add(0, 1, 'b0010,  1, 1, 0, 0, 0, 1, 2);
        add(0, 1, 'b0100,  2, 1, 0, 0, 0, 1, 2);
        add(0, 1, 'b1000,  3, 1, 0, 0, 0, 1, 2);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 1, 2);
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 1, 2);
        // skip error, then relock after 4 in-sequence samples
        add(0, 1, 'b1000,  3, 1, 0, 1, 0, 1, 3);
        add(0, 1, 'b0001,  0, 1, 0, 0, 0, 1, 3);
        add(0, 1, 'b0010,  1, 1, 0, 0, 0, 1, 3);
        add(0, 1, 'b0100,  2, 1, 0, 0, 0, 1, 3);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 1, 3);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 2, 3);
        add(0, 0, 'b0110,  0, 0, 0, 0, 1, 2, 3);
        // reset wins over a valid sample, then gapped nominal run
        add(1, 1, 'b0100,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 'b1111,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 'b1111,  1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 0, 0, 0);
        add(0, 0, 'b1111,  2, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 0, 0, 0);
        add(0, 0, 'b1111,  3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 0, 0);
        add(0, 0, 'b1111,  0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 0, 0);
        add(0, 0, 'b1111,  1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 1, 0, 0);
        add(0, 0, 'b1111,  2, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 0, 0);
        add(0, 0, 'b1111,  3, 0, 0, 0, 1, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 1, 0);
        add(0, 0, 'b1111,  0, 0, 0, 0, 1, 1, 0);
        // continue back-to-back up to Rev_count=3
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 1, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 2, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 1, 2, 0);
        add(0, 1, 'b0100,  2, 1, 0, 0, 1, 2, 0);
        add(0, 1, 'b1000,  3, 1, 0, 0, 1, 2, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 1, 3, 0);
        // reset mid-run, then reacquire from IDLE
        add(1, 0, 'b0000,  0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 'b0001,  0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 'b0010,  1, 1, 0, 0, 0, 0, 0);

        rst = 1'b1; vld = 1'b0; ring = '0;
        rst2 = 1'b1; vld2 = 1'b0; ring2 = '0;

        for (int r = 0; r < tbl.size(); r++) begin
            rst  = 1'(tbl[r].rst);
            vld  = 1'(tbl[r].vld);
            ring = 4'(tbl[r].ring);
            @(posedge clk);
            #1;
            chk("Index",       r, int'(idx), tbl[r].idx);
            chk("Index_valid", r, int'(iv),  tbl[r].iv);
            chk("Onehot_err",  r, int'(oh),  tbl[r].oh);
            chk("Seq_err",     r, int'(sq),  tbl[r].sq);
            chk("Locked",      r, int'(lk),  tbl[r].lk);
            chk("Rev_count",   r, int'(rev), tbl[r].rev);
            chk("Err_count",   r, int'(err), tbl[r].err);
        end

        // Saturation: ERR_W=2, five 0000 samples separated by idle cycles
        rst = 1'b1; vld = 1'b0;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("sat_reset_err", 0, int'(err2), 0);
        rst2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vld2 = 1'b1; ring2 = 4'b0000;
            @(posedge clk);
            #1;
            chk("sat_onehot_err", k, int'(oh2),  1);
            chk("sat_err_count",  k, int'(err2), sat_exp[k]);
            chk("sat_seq_err",    k, int'(sq2),  0);
            chk("sat_locked",     k, int'(lk2),  0);
            chk("sat_index_vld",  k, int'(iv2),  0);
            chk("sat_index",      k, int'(idx2), 0);
            chk("sat_rev",        k, int'(rev2), 0);
            vld2 = 1'b0; ring2 = 4'b0110;
            @(posedge clk);
            #1;
            chk("sat_gap_pulse",  k, int'(oh2),  0);
            chk("sat_gap_err",    k, int'(err2), sat_exp[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
